// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_e          : arbiter FSM states (IDLE, IBUSY, DBUSY)
//   BE_ALL               : full-word byte-enable pattern used for fetches
//   ADDR_W_DEFAULT       : default memory word-index width
//   STARVE_LIMIT_DEFAULT : default number of consecutive data grants allowed
//                          while a fetch is waiting
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    localparam logic [3:0] BE_ALL = 4'hF;

    localparam int ADDR_W_DEFAULT       = 21;
    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported, word-addressed, variable-latency memory
// between the instruction-fetch port and the load/store data port.
// Data accesses win by default; a saturating counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants taken while a fetch was waiting.
//
// Ports
//   clk, reset                 : core clock, synchronous active-high reset
//   ireq, iaddr                : fetch request / byte address
//   irdata, iready             : fetched word (registered), 1-cycle done pulse
//   dreq, dwe, daddr, dwdata,
//   dbe                        : data request, write enable, byte address,
//                                write data, write byte enables
//   drdata, dready             : read data (registered), 1-cycle done pulse
//   mreq, mwe, maddr, mwdata,
//   mbe                        : memory request (high for the whole access)
//                                and registered access attributes
//   mrdata, mready             : memory read data and 1-cycle completion
//
// Parameters
//   ADDR_W       : memory word-index width; maddr = addr[ADDR_W+1:2]
//   STARVE_LIMIT : data grants allowed back to back while a fetch waits (1..15)
module imem_dmem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ireq,
    input  logic [31:0]       iaddr,
    output logic [31:0]       irdata,
    output logic              iready,

    input  logic              dreq,
    input  logic              dwe,
    input  logic [31:0]       daddr,
    input  logic [31:0]       dwdata,
    input  logic [3:0]        dbe,
    output logic [31:0]       drdata,
    output logic              dready,

    output logic              mreq,
    output logic              mwe,
    output logic [ADDR_W-1:0] maddr,
    output logic [31:0]       mwdata,
    output logic [3:0]        mbe,
    input  logic [31:0]       mrdata,
    input  logic              mready
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state;
    arb_state_e state_nxt;
    logic [3:0] starve_cnt;
    logic       grant_i;
    logic       grant_d;
    logic       fetch_starved;

    // Only addr[ADDR_W+1:2] selects a word; the byte offset and the bits above
    // the memory size are dropped, so addresses wrap around the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iaddr, daddr};

    // ------------------------------------------------------------------
    // Grant decision / next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        fetch_starved = ireq && (starve_cnt == LIMIT);

        case (state)
            IDLE: begin
                // While a ready pulse is out, the requester still shows the
                // request it is just finishing; hold off one cycle so the
                // next grant samples the updated request and address.
                if (!(iready || dready)) begin
                    if (dreq && !fetch_starved) begin
                        grant_d   = 1'b1;
                        state_nxt = DBUSY;
                    end else if (ireq) begin
                        grant_i   = 1'b1;
                        state_nxt = IBUSY;
                    end
                end
            end
            IBUSY, DBUSY: begin
                if (mready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, memory interface and requester response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            mreq       <= 1'b0;
            mwe        <= 1'b0;
            maddr      <= '0;
            mwdata     <= 32'd0;
            mbe        <= 4'd0;
            iready     <= 1'b0;
            dready     <= 1'b0;
            irdata     <= 32'd0;
            drdata     <= 32'd0;
        end else begin
            state  <= state_nxt;
            iready <= 1'b0;
            dready <= 1'b0;

            if (grant_d) begin
                mreq   <= 1'b1;
                mwe    <= dwe;
                maddr  <= daddr[ADDR_W+1:2];
                mwdata <= dwdata;
                mbe    <= dbe;
                // Count only the data grants that overtook a waiting fetch.
                if (ireq) begin
                    if (starve_cnt != LIMIT) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end else begin
                    starve_cnt <= 4'd0;
                end
            end

            if (grant_i) begin
                mreq       <= 1'b1;
                mwe        <= 1'b0;
                maddr      <= iaddr[ADDR_W+1:2];
                mbe        <= BE_ALL;
                starve_cnt <= 4'd0;
            end

            // mready outside IBUSY/DBUSY is deliberately ignored.
            if (state == IBUSY && mready) begin
                mreq   <= 1'b0;
                irdata <= mrdata;
                iready <= 1'b1;
            end

            if (state == DBUSY && mready) begin
                mreq   <= 1'b0;
                dready <= 1'b1;
                if (!mwe) begin
                    drdata <= mrdata;
                end
            end
        end
    end

    // Requesters must keep a request up until its ready pulse has been seen.
    ireq_held_until_ready: assert property (
        @(posedge clk) disable iff (reset) $fell(ireq) |-> $past(iready));
    dreq_held_until_ready: assert property (
        @(posedge clk) disable iff (reset) $fell(dreq) |-> $past(dready));
    ready_pulses_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(iready && dready));

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported, word-addressed, variable-latency memory between two requesters of the pipelined ARM core: instruction fetch (read-only) and the data/load-store port.
- Sits between the core's fetch and memory stages and the unified memory array.
- Arbitrates one access at a time and holds the losing requester via its ready signal.
- Data accesses have priority, since they belong to older instructions. A starvation guard guarantees fetch progress.

Parameters:
- ADDR_W, 21, memory word-index width; the memory word index is addr[ADDR_W+1:2].
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending (range 1..15).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ireq  in  1  fetch request; held until iready
- iaddr  in  32  fetch byte address; stable while ireq is high
- irdata  out  32  fetched word, registered
- iready  out  1  one-cycle pulse; irdata is valid
- dreq  in  1  data request; held until dready
- dwe  in  1  1 = write, 0 = read
- daddr  in  32  data byte address
- dwdata  in  32  write data
- dbe  in  4  byte enables for writes
- drdata  out  32  read data, registered
- dready  out  1  one-cycle pulse; access complete
- mreq  out  1  memory request, high for the whole access
- mwe  out  1  memory write enable
- maddr  out  ADDR_W  word index
- mwdata  out  32  memory write data
- mbe  out  4  memory byte enables
- mrdata  in  32  memory read data, valid with mready
- mready  in  1  memory completion, one-cycle pulse

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state = IDLE; mreq, mwe, iready, dready = 0; maddr, mwdata, mbe, irdata, drdata = 0; starvation counter = 0.
- Reset asserted mid-access aborts the access with no ready pulse. Any late mready is ignored.
- States: IDLE, IBUSY, DBUSY.
- IDLE:
  - If dreq=1 and not (ireq=1 and cnt==STARVE_LIMIT), go to DBUSY.
  - Else if ireq=1, go to IBUSY.
  - Else stay in IDLE.
- On a grant, the following are registered: maddr = addr[ADDR_W+1:2], mwe, mwdata, mbe. For instruction grants, mwe=0 and mbe=4'hF. Registered mreq is asserted from the next cycle.
- IBUSY/DBUSY:
  - mreq is held at 1 and all m* outputs are held stable.
  - On the cycle mready=1: capture mrdata into irdata or drdata (data reads only; drdata is unchanged on writes), pulse the matching ready output for 1 cycle, and return to IDLE.
- Minimum latency from the grant cycle to ready is 2 cycles, plus the memory latency.
- One mandatory IDLE cycle follows each completion. Requesters update their address at the ready edge, so the next grant samples the new address.
- mready received in IDLE is ignored.
- The iready and dready pulses are never asserted in the same cycle.
- Starvation counter:
  - On a data grant with ireq=1: cnt increments, saturating at STARVE_LIMIT.
  - On a data grant with ireq=0: cnt clears.
  - On any instruction grant: cnt clears.
- Address handling:
  - addr[1:0] is ignored (word-aligned access).
  - Bits above ADDR_W+1 are ignored (addresses wrap modulo 2^(ADDR_W+2) bytes).
  - No alignment fault is raised.
- Requester rules: dropping a request before its ready pulse is illegal. The assertion ireq falls -> iready was seen (and likewise for dreq/dready) is checked in simulation only.
- Read data outputs hold their last captured value until the next completion on the same port.

Decomposition:
- Package arm_mem_pkg holds:
  - the state enum (IDLE, IBUSY, DBUSY);
  - the constant BE_ALL = 4'hF;
  - the default ADDR_W and STARVE_LIMIT.
- The block is one module, with no sub-module. The starvation counter is a 4-bit register inside the arbiter.

Test Plan:
- Single fetch: ireq=1, iaddr=0x0000_0010, memory returns 0xE3A0_0001 after 3 cycles -> maddr=4, mwe=0, mbe=F, iready pulses once, irdata=0xE3A0_0001, dready stays 0.
- Simultaneous requests: ireq=dreq=1 at the same cycle, data read daddr=0x100 -> data served first (maddr=0x40), dready; then IDLE for one cycle; then fetch served, iready.
- Data write: dwe=1, daddr=0x0080_0007, dwdata=0xDEAD_BEEF, dbe=4'b0011 -> maddr=0x000001 (wrap plus alignment), mwe=1, mbe=3, dready pulses, drdata unchanged.
- Starvation: ireq held high and 6 back-to-back data requests, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D; cnt clears after the I grant.
- Reset mid-access: reset asserted during DBUSY before mready -> next cycle mreq=0, all outputs 0; a late mready produces no dready.
- Zero-latency memory (mready=1 in the first mreq cycle) and long latency (20 cycles) -> m* outputs stay stable throughout; exactly one ready pulse per access.
